// File: rtl/run_detect_ctrl.sv
// ---------------------------------------------------------------------------
// run_detect_ctrl
//
// Control and reporting wrapper around a serial run-length detector.
// The block watches the serial bit w and tracks the current run of 0s and
// the current run of 1s. When either run reaches the programmed threshold,
// it counts a hit and raises an interrupt. The interrupt stays high until
// the host acknowledges it or an acknowledge timeout expires.
//
// Parameters
//   THR_W   width of the threshold and of both run counters
//   CNT_W   width of the saturating hit counter
//   ACK_TO  cycles spent in REPORT without ack before timing out (>= 1)
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   w          serial data, sampled on every clock edge
//   start      one-cycle pulse; arms the block and latches thr
//   stop       one-cycle pulse; returns the block to IDLE
//   thr        run length to detect; a value of 0 is treated as 1
//   ack        host acknowledge of irq
//   irq        hit pending (high while in REPORT)
//   hit_level  bit value of the last reported run
//   hit_count  hits since the last start; saturates at all-ones
//   overrun    sticky flag; set by a hit while irq is pending, or by an
//              acknowledge timeout
//   busy       high in every state other than IDLE
// ---------------------------------------------------------------------------
`default_nettype none

module run_detect_ctrl #(
  parameter int THR_W  = 4,
  parameter int CNT_W  = 8,
  parameter int ACK_TO = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             w,
  input  logic             start,
  input  logic             stop,
  input  logic [THR_W-1:0] thr,
  input  logic             ack,
  output logic             irq,
  output logic             hit_level,
  output logic [CNT_W-1:0] hit_count,
  output logic             overrun,
  output logic             busy
);

  // The ack timer only has to reach ACK_TO-1, so $clog2(ACK_TO) bits are
  // enough. One bit is kept as a minimum so that ACK_TO == 1 still builds.
  localparam int               TMR_W    = (ACK_TO > 1) ? $clog2(ACK_TO) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TO - 1);

  // The encoding is fixed. The unused value 3 is decoded as IDLE.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ARMED  = 2'd1;
  localparam logic [1:0] ST_REPORT = 2'd2;

  // Architectural state. Every output below is driven directly by one of
  // these registers.
  logic [1:0]       r_state;
  logic [THR_W-1:0] r_thrQ;
  logic [THR_W-1:0] r_oneRun;
  logic [THR_W-1:0] r_zeroRun;
  logic [TMR_W-1:0] r_timer;
  logic             r_irq;
  logic             r_hitLevel;
  logic [CNT_W-1:0] r_hitCount;
  logic             r_overrun;
  logic             r_busy;

  // Next-state values, plus helper terms for the run counters.
  logic [1:0]       w_stateNxt;
  logic [THR_W-1:0] w_thrQNxt;
  logic [THR_W-1:0] w_oneRunNxt;
  logic [THR_W-1:0] w_zeroRunNxt;
  logic [TMR_W-1:0] w_timerNxt;
  logic             w_hitLevelNxt;
  logic [CNT_W-1:0] w_hitCountNxt;
  logic             w_overrunNxt;
  logic             w_active;
  logic [THR_W-1:0] w_oneStep;
  logic [THR_W-1:0] w_zeroStep;
  logic             w_det;
  logic [CNT_W-1:0] w_hitInc;
  logic [THR_W-1:0] w_thrLoad;

  // Run counters and hit detection. Each counter saturates at the latched
  // threshold. A hit (det) is the single step from thr_q-1 to thr_q, so a
  // run longer than the threshold produces only one hit. A start or stop
  // in the same cycle takes priority over normal operation, which
  // suppresses det.
  always_comb begin
    w_active   = (r_state == ST_ARMED) || (r_state == ST_REPORT);
    w_oneStep  = (r_oneRun  >= r_thrQ) ? r_thrQ : r_oneRun  + 1'b1;
    w_zeroStep = (r_zeroRun >= r_thrQ) ? r_thrQ : r_zeroRun + 1'b1;
    w_det      = 1'b0;
    if (w_active && !stop && !start) begin
      if (w) begin
        w_det = (r_oneRun == (r_thrQ - 1'b1));
      end else begin
        w_det = (r_zeroRun == (r_thrQ - 1'b1));
      end
    end
    w_hitInc  = (&r_hitCount) ? r_hitCount : r_hitCount + 1'b1;
    w_thrLoad = (thr == '0) ? THR_W'(1) : thr;
  end

  // Main control. Priority is stop, then start, then the normal ARMED or
  // REPORT behaviour. While irq is pending, an ack alone releases the
  // interrupt. An ack that coincides with a new hit re-reports that hit
  // instead. A hit without ack is counted but flagged as an overrun.
  always_comb begin
    w_stateNxt    = r_state;
    w_thrQNxt     = r_thrQ;
    w_oneRunNxt   = r_oneRun;
    w_zeroRunNxt  = r_zeroRun;
    w_timerNxt    = r_timer;
    w_hitLevelNxt = r_hitLevel;
    w_hitCountNxt = r_hitCount;
    w_overrunNxt  = r_overrun;

    if (stop) begin
      w_stateNxt   = ST_IDLE;
      w_oneRunNxt  = '0;
      w_zeroRunNxt = '0;
      w_timerNxt   = '0;
    end else if (start) begin
      w_stateNxt    = ST_ARMED;
      w_thrQNxt     = w_thrLoad;
      w_oneRunNxt   = '0;
      w_zeroRunNxt  = '0;
      w_timerNxt    = '0;
      w_hitCountNxt = '0;
      w_overrunNxt  = 1'b0;
    end else begin
      if (w_active) begin
        if (w) begin
          w_oneRunNxt  = w_oneStep;
          w_zeroRunNxt = '0;
        end else begin
          w_zeroRunNxt = w_zeroStep;
          w_oneRunNxt  = '0;
        end
      end
      case (r_state)
        ST_ARMED: begin
          if (w_det) begin
            w_stateNxt    = ST_REPORT;
            w_hitLevelNxt = w;
            w_hitCountNxt = w_hitInc;
            w_timerNxt    = '0;
          end
        end
        ST_REPORT: begin
          if (ack) begin
            if (w_det) begin
              w_hitLevelNxt = w;
              w_hitCountNxt = w_hitInc;
              w_timerNxt    = '0;
            end else begin
              w_stateNxt = ST_ARMED;
              w_timerNxt = '0;
            end
          end else begin
            if (w_det) begin
              w_overrunNxt  = 1'b1;
              w_hitCountNxt = w_hitInc;
            end
            if (r_timer == TMR_LAST) begin
              w_stateNxt   = ST_ARMED;
              w_overrunNxt = 1'b1;
              w_timerNxt   = '0;
            end else begin
              w_timerNxt = r_timer + 1'b1;
            end
          end
        end
        default: begin
          w_stateNxt = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers. irq and busy are decoded from the next
  // state, so both are registered and line up with the state they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_thrQ     <= THR_W'(1);
      r_oneRun   <= '0;
      r_zeroRun  <= '0;
      r_timer    <= '0;
      r_irq      <= 1'b0;
      r_hitLevel <= 1'b0;
      r_hitCount <= '0;
      r_overrun  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_stateNxt;
      r_thrQ     <= w_thrQNxt;
      r_oneRun   <= w_oneRunNxt;
      r_zeroRun  <= w_zeroRunNxt;
      r_timer    <= w_timerNxt;
      r_irq      <= (w_stateNxt == ST_REPORT);
      r_hitLevel <= w_hitLevelNxt;
      r_hitCount <= w_hitCountNxt;
      r_overrun  <= w_overrunNxt;
      r_busy     <= (w_stateNxt != ST_IDLE);
    end
  end

  assign irq       = r_irq;
  assign hit_level = r_hitLevel;
  assign hit_count = r_hitCount;
  assign overrun   = r_overrun;
  assign busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_run_detect_ctrl.sv
// ---------------------------------------------------------------------------
// tb_run_detect_ctrl
//
// Bench for run_detect_ctrl. Two instances share one stimulus stream: one
// with an 8-bit hit counter and one with a 2-bit hit counter, so counter
// saturation can be observed. Both use ACK_TO = 5. The reference model
// treats the input as a single current run (a bit value and an unbounded
// length) and holds the hit count as a plain integer. Saturation is
// applied only when the model's value is compared with the DUT.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_run_detect_ctrl;

  localparam int ACK_TO = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       w = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] thr = 4'd0;
  logic       ack = 1'b0;

  logic       irqA, levelA, overA, busyA;
  logic [7:0] countA;
  logic       irqB, levelB, overB, busyB;
  logic [1:0] countB;

  int nChecks = 0;
  int nErrors = 0;

  // Reference model state
  bit mArmed, mPending, runBit, mLevel, mOver;
  int mThr, runLen, mHits, mAge;

  // 10-unit clock period; rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  run_detect_ctrl #(.THR_W(4), .CNT_W(8), .ACK_TO(ACK_TO)) dutA (
    .clk(clk), .reset(reset), .w(w), .start(start), .stop(stop), .thr(thr),
    .ack(ack), .irq(irqA), .hit_level(levelA), .hit_count(countA),
    .overrun(overA), .busy(busyA)
  );

  run_detect_ctrl #(.THR_W(4), .CNT_W(2), .ACK_TO(ACK_TO)) dutB (
    .clk(clk), .reset(reset), .w(w), .start(start), .stop(stop), .thr(thr),
    .ack(ack), .irq(irqB), .hit_level(levelB), .hit_count(countB),
    .overrun(overB), .busy(busyB)
  );

  // Single comparison point: counts the check and reports any mismatch
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nChecks++;
    if (observed !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at t=%0t",
               tag, observed, expected, $time);
    end
  endtask

  function automatic int satCount(input int hits, input int width);
    int maxVal;
    maxVal = (1 << width) - 1;
    return (hits > maxVal) ? maxVal : hits;
  endfunction

  task automatic modelReset();
    mArmed = 0; mPending = 0; runBit = 0; runLen = 0; mLevel = 0;
    mOver = 0; mThr = 1; mHits = 0; mAge = 0;
  endtask

  // One clock cycle of behaviour, computed from the inputs currently driven
  task automatic modelStep();
    bit det;
    if (stop) begin
      mArmed = 0; mPending = 0; runLen = 0;
    end else if (start) begin
      mThr = (thr == 0) ? 1 : int'(thr);
      mHits = 0; mOver = 0; runLen = 0; mArmed = 1; mPending = 0;
    end else if (mArmed) begin
      if (runLen > 0 && w == runBit) runLen++;
      else begin
        runBit = w; runLen = 1;
      end
      det = (runLen == mThr);
      if (!mPending) begin
        if (det) begin
          mPending = 1; mLevel = w; mHits++; mAge = 0;
        end
      end else if (ack) begin
        if (det) begin
          mLevel = w; mHits++; mAge = 0;
        end else mPending = 0;
      end else begin
        if (det) begin
          mOver = 1; mHits++;
        end
        mAge++;
        if (mAge == ACK_TO) mPending = 0;
        if (mAge == ACK_TO) mOver = 1;
      end
    end
  endtask

  task automatic checkAll();
    checkOutput("irqA",   32'(irqA),   32'(mPending));
    checkOutput("busyA",  32'(busyA),  32'(mArmed));
    checkOutput("levelA", 32'(levelA), 32'(mLevel));
    checkOutput("countA", 32'(countA), 32'(satCount(mHits, 8)));
    checkOutput("overA",  32'(overA),  32'(mOver));
    checkOutput("irqB",   32'(irqB),   32'(mPending));
    checkOutput("countB", 32'(countB), 32'(satCount(mHits, 2)));
    checkOutput("overB",  32'(overB),  32'(mOver));
  endtask

  // Drive one cycle of inputs, step the model, clock, then check outputs
  task automatic applyStimulus(input bit iStart, input bit iStop, input bit iW,
                               input bit iAck, input logic [3:0] iThr);
    start = iStart; stop = iStop; w = iW; ack = iAck; thr = iThr;
    modelStep();
    @(posedge clk);
    #1;
    checkAll();
  endtask

  initial begin
    bit prevW;
    modelReset();

    // Reset state
    #2 reset = 1'b0;
    #1;
    checkAll();
    @(posedge clk); @(posedge clk); #1;
    checkAll();
    reset = 1'b1;

    // 1: thr=3, three zeros -> hit after the third edge
    applyStimulus(1, 0, 0, 0, 4'd3);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 4'd0);
    checkOutput("t1_irq", 32'(irqA), 32'd1);
    checkOutput("t1_level", 32'(levelA), 32'd0);
    checkOutput("t1_count", 32'(countA), 32'd1);

    // 2: thr=2, six ones, ack on the first irq cycle -> one hit only
    applyStimulus(1, 0, 0, 0, 4'd2);
    applyStimulus(0, 0, 1, 0, 4'd0);
    applyStimulus(0, 0, 1, 0, 4'd0);
    checkOutput("t2_irq_on", 32'(irqA), 32'd1);
    applyStimulus(0, 0, 1, 1, 4'd0);
    checkOutput("t2_irq_off", 32'(irqA), 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 4'd0);
    checkOutput("t2_count", 32'(countA), 32'd1);

    // 3: thr=2, 1,1 then 0,0 without ack -> overrun, then ack timeout
    applyStimulus(1, 0, 0, 0, 4'd2);
    applyStimulus(0, 0, 1, 0, 4'd0);
    applyStimulus(0, 0, 1, 0, 4'd0);
    applyStimulus(0, 0, 0, 0, 4'd0);
    applyStimulus(0, 0, 0, 0, 4'd0);
    checkOutput("t3_over", 32'(overA), 32'd1);
    checkOutput("t3_count", 32'(countA), 32'd2);
    checkOutput("t3_level", 32'(levelA), 32'd1);
    applyStimulus(0, 0, 0, 0, 4'd0);
    applyStimulus(0, 0, 0, 0, 4'd0);
    checkOutput("t3_irq_held", 32'(irqA), 32'd1);
    applyStimulus(0, 0, 0, 0, 4'd0);
    checkOutput("t3_irq_timeout", 32'(irqA), 32'd0);

    // 4: thr=0 acts as 1; ack together with a hit keeps REPORT
    applyStimulus(1, 0, 0, 0, 4'd0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, (i % 2) == 0, 1, 4'd0);
    checkOutput("t4_irq", 32'(irqA), 32'd1);
    checkOutput("t4_over", 32'(overA), 32'd0);
    checkOutput("t4_count", 32'(countA), 32'd4);
    checkOutput("t4_level", 32'(levelA), 32'd0);

    // 5: start+stop while ARMED -> IDLE; async reset while in REPORT
    applyStimulus(1, 0, 0, 0, 4'd3);
    applyStimulus(0, 0, 1, 0, 4'd0);
    applyStimulus(1, 1, 1, 0, 4'd3);
    checkOutput("t5_busy", 32'(busyA), 32'd0);
    applyStimulus(1, 0, 0, 0, 4'd1);
    applyStimulus(0, 0, 1, 0, 4'd0);
    checkOutput("t5_in_report", 32'(irqA), 32'd1);
    #1 reset = 1'b0;
    #1;
    checkOutput("t5_rst_irq", 32'(irqA), 32'd0);
    checkOutput("t5_rst_busy", 32'(busyA), 32'd0);
    checkOutput("t5_rst_count", 32'(countA), 32'd0);
    checkOutput("t5_rst_level", 32'(levelA), 32'd0);
    checkOutput("t5_rst_over", 32'(overA), 32'd0);
    modelReset();
    #1 reset = 1'b1;

    // 6: five hits -> 2-bit counter saturates at 3
    applyStimulus(1, 0, 0, 0, 4'd1);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, (i % 2) == 0, i > 0, 4'd0);
    checkOutput("t6_countB", 32'(countB), 32'd3);
    checkOutput("t6_countA", 32'(countA), 32'd5);

    // Randomized operation against the model
    prevW = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      bit rStart, rStop, rW, rAck;
      logic [3:0] rThr;
      rStart = ($urandom_range(0, 29) == 0) || (!mArmed && $urandom_range(0, 2) == 0);
      rStop  = ($urandom_range(0, 59) == 0);
      rW     = ($urandom_range(0, 2) == 0) ? ~prevW : prevW;
      rAck   = ($urandom_range(0, 5) == 0);
      rThr   = 4'($urandom_range(0, 4));
      prevW  = rW;
      applyStimulus(rStart, rStop, rW, rAck, rThr);
    end

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule

`default_nettype wire
